// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates pipeline writeback and an MDU skid FIFO onto the regfile write port, with MDU scoreboard stall
// Optional feature macro REGFILE_BYPASS_EN: bypass outputs and pending-clear at the FIFO pop edge.
module regfile_wb_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_reg,
    input  logic [31:0] pipe_data,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_reg,
    input  logic [31:0] mdu_data,
    input  logic        issue_mdu,
    input  logic [4:0]  issue_reg,
    input  logic [4:0]  ctrl_readRegA,
    input  logic [4:0]  ctrl_readRegB,
    input  logic [4:0]  dec_dst,
    output logic        stall,
    output logic        pipe_hold,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [31:0] data_writeReg,
    output logic        err_sticky
`ifdef REGFILE_BYPASS_EN
    , output logic        bypass_hitA
    , output logic        bypass_hitB
    , output logic [31:0] bypass_data
`endif
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(STARVE_LIMIT - 1);

    logic [1:0][4:0]  freg_q, freg_d;
    logic [1:0][31:0] fdata_q, fdata_d;
    logic [1:0]       count_q, count_d;
    logic [CW-1:0]    starve_q, starve_d;
    logic             hold_q, hold_d;
    logic             we_q, we_d;
    logic [4:0]       wreg_q, wreg_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             err_q, err_d;
    logic [31:0]      pending_q, pending_d;
    logic             non_empty, push, pop, pipe_sel, slot, clr_en;
    logic [4:0]       head_reg, clr_reg;
    logic [31:0]      head_data;

    assign non_empty = count_q != 2'd0;
    assign mdu_ready = count_q != 2'(FIFO_DEPTH);
    assign push      = mdu_valid & mdu_ready;
    assign head_reg  = freg_q[0];
    assign head_data = fdata_q[0];
    assign pop       = non_empty & (hold_q | ~(pipe_we & |pipe_reg));
    assign pipe_sel  = pipe_we & |pipe_reg & ~(hold_q & non_empty);
    // push only happens with at most one entry left after the pop, so the write slot is 0 or 1
    assign slot      = count_q[0] & ~pop;

`ifdef REGFILE_BYPASS_EN
    assign clr_en  = pop;
    assign clr_reg = head_reg;
    assign bypass_hitA = we_q & (wreg_q == ctrl_readRegA);
    assign bypass_hitB = we_q & (wreg_q == ctrl_readRegB);
    assign bypass_data = wdata_q;
`else
    logic mdu_wb_q;
    assign clr_en  = mdu_wb_q;
    assign clr_reg = wreg_q;
    // remembers that the write now on the output registers came from the FIFO
    always_ff @(posedge clock) mdu_wb_q <= ctrl_reset ? 1'b0 : pop;
`endif

    assign stall = pending_q[ctrl_readRegA] | pending_q[ctrl_readRegB] | pending_q[dec_dst] | (issue_mdu & pending_q[issue_reg]);
    assign pipe_hold        = hold_q;
    assign ctrl_writeEnable = we_q;
    assign ctrl_writeReg    = wreg_q;
    assign data_writeReg    = wdata_q;
    assign err_sticky       = err_q;

    // skid FIFO: shift on pop, then place the new entry behind whatever remains
    always_comb begin
        freg_d  = freg_q;
        fdata_d = fdata_q;
        if (pop) begin
            freg_d[0]  = freg_q[1];
            fdata_d[0] = fdata_q[1];
        end
        if (push) begin
            freg_d[slot]  = mdu_reg;
            fdata_d[slot] = mdu_data;
        end
        count_d = count_q - {1'b0, pop} + {1'b0, push};
    end

    // write selection, starvation tracking and scoreboard next state
    always_comb begin
        we_d      = pipe_sel | (pop & |head_reg);
        wreg_d    = pipe_sel ? pipe_reg : head_reg;
        wdata_d   = pipe_sel ? pipe_data : head_data;
        err_d     = err_q | (hold_q & pipe_we);
        hold_d    = non_empty & ~pop & (starve_q == LAST_WAIT);
        starve_d  = (~non_empty | pop | hold_d) ? '0 : starve_q + 1'b1;
        pending_d = pending_q;
        if (clr_en) pending_d[clr_reg] = 1'b0;
        if (issue_mdu) pending_d[issue_reg] = 1'b1;
        pending_d[0] = 1'b0;
    end

    // state registers; reset also drops the write in flight and clears all bookkeeping
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            freg_q    <= '0;
            fdata_q   <= '0;
            count_q   <= '0;
            starve_q  <= '0;
            hold_q    <= 1'b0;
            we_q      <= 1'b0;
            wreg_q    <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            pending_q <= '0;
        end else begin
            freg_q    <= freg_d;
            fdata_q   <= fdata_d;
            count_q   <= count_d;
            starve_q  <= starve_d;
            hold_q    <= hold_d;
            we_q      <= we_d;
            wreg_q    <= wreg_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            pending_q <= pending_d;
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    logic        clock = 1'b0;
    logic        ctrl_reset = 1'b1;
    logic        pipe_we, mdu_valid, issue_mdu;
    logic [4:0]  pipe_reg, mdu_reg, issue_reg, ctrl_readRegA, ctrl_readRegB, dec_dst;
    logic [31:0] pipe_data, mdu_data;
    logic        mdu_ready, stall, pipe_hold, ctrl_writeEnable, err_sticky;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
`ifdef REGFILE_BYPASS_EN
    logic        bypass_hitA, bypass_hitB;
    logic [31:0] bypass_data;
`endif
    int tests = 0;
    int fails = 0;

    regfile_wb_arbiter dut (
        .clock(clock), .ctrl_reset(ctrl_reset),
        .pipe_we(pipe_we), .pipe_reg(pipe_reg), .pipe_data(pipe_data),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_reg(mdu_reg), .mdu_data(mdu_data),
        .issue_mdu(issue_mdu), .issue_reg(issue_reg),
        .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB), .dec_dst(dec_dst),
        .stall(stall), .pipe_hold(pipe_hold),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
        .err_sticky(err_sticky)
`ifdef REGFILE_BYPASS_EN
        , .bypass_hitA(bypass_hitA), .bypass_hitB(bypass_hitB), .bypass_data(bypass_data)
`endif
    );

    always #5 clock = ~clock;

    task automatic idle();
        pipe_we = 0; pipe_reg = 0; pipe_data = 0;
        mdu_valid = 0; mdu_reg = 0; mdu_data = 0;
        issue_mdu = 0; issue_reg = 0;
        ctrl_readRegA = 0; ctrl_readRegB = 0; dec_dst = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        idle();
        ctrl_reset = 1; pipe_we = 1; pipe_reg = 5; pipe_data = 32'hFFFF;
        tick(); tick();
        tests++; if (ctrl_writeEnable !== 1'b0) begin fails++; $display("FAIL reset_we: got %b want 0", ctrl_writeEnable); end
        tests++; if (mdu_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", mdu_ready); end
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", stall); end
        tests++; if (err_sticky !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err_sticky); end
        tests++; if (pipe_hold !== 1'b0) begin fails++; $display("FAIL reset_hold: got %b want 0", pipe_hold); end
        ctrl_reset = 0; pipe_we = 0;
    endtask

    task automatic test_pipe_write();
        idle();
        pipe_we = 1; pipe_reg = 3; pipe_data = 32'hDEADBEEF;
        tick();
        tests++; if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b1, 5'd3, 32'hDEADBEEF}) begin fails++; $display("FAIL pipe_write: got %h want %h", {ctrl_writeEnable, ctrl_writeReg, data_writeReg}, {1'b1, 5'd3, 32'hDEADBEEF}); end
        pipe_we = 0;
        tick();
        tests++; if (ctrl_writeEnable !== 1'b0) begin fails++; $display("FAIL pipe_idle: got %b want 0", ctrl_writeEnable); end
    endtask

    task automatic test_contention();
        idle();
        mdu_valid = 1; mdu_reg = 7; mdu_data = 32'h1234;
        tick();
        tests++; if (ctrl_writeEnable !== 1'b0) begin fails++; $display("FAIL cont_push_we: got %b want 0", ctrl_writeEnable); end
        tests++; if (mdu_ready !== 1'b1) begin fails++; $display("FAIL cont_ready: got %b want 1", mdu_ready); end
        mdu_valid = 0; pipe_we = 1; pipe_reg = 5; pipe_data = 32'hAAAA0000;
        tick();
        tests++; if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b1, 5'd5, 32'hAAAA0000}) begin fails++; $display("FAIL cont_pipe: got %h want %h", {ctrl_writeEnable, ctrl_writeReg, data_writeReg}, {1'b1, 5'd5, 32'hAAAA0000}); end
        pipe_we = 0;
        tick();
        tests++; if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b1, 5'd7, 32'h1234}) begin fails++; $display("FAIL cont_mdu: got %h want %h", {ctrl_writeEnable, ctrl_writeReg, data_writeReg}, {1'b1, 5'd7, 32'h1234}); end
        tick();
        tests++; if (ctrl_writeEnable !== 1'b0) begin fails++; $display("FAIL cont_idle: got %b want 0", ctrl_writeEnable); end
    endtask

    task automatic test_full_fifo();
        idle();
        mdu_valid = 1; mdu_reg = 10; mdu_data = 32'h10; pipe_we = 1; pipe_reg = 1; pipe_data = 1;
        tests++; if (mdu_ready !== 1'b1) begin fails++; $display("FAIL full_ready1: got %b want 1", mdu_ready); end
        tick();
        tests++; if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b1, 5'd1, 32'd1}) begin fails++; $display("FAIL full_p1: got %h want %h", {ctrl_writeEnable, ctrl_writeReg, data_writeReg}, {1'b1, 5'd1, 32'd1}); end
        mdu_reg = 11; mdu_data = 32'h11; pipe_reg = 2; pipe_data = 2;
        tests++; if (mdu_ready !== 1'b1) begin fails++; $display("FAIL full_ready2: got %b want 1", mdu_ready); end
        tick();
        tests++; if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b1, 5'd2, 32'd2}) begin fails++; $display("FAIL full_p2: got %h want %h", {ctrl_writeEnable, ctrl_writeReg, data_writeReg}, {1'b1, 5'd2, 32'd2}); end
        mdu_reg = 12; mdu_data = 32'h12; pipe_reg = 3; pipe_data = 3;
        tests++; if (mdu_ready !== 1'b0) begin fails++; $display("FAIL full_ready3: got %b want 0", mdu_ready); end
        tick();
        tests++; if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b1, 5'd3, 32'd3}) begin fails++; $display("FAIL full_p3: got %h want %h", {ctrl_writeEnable, ctrl_writeReg, data_writeReg}, {1'b1, 5'd3, 32'd3}); end
        pipe_we = 0;
        tests++; if (mdu_ready !== 1'b0) begin fails++; $display("FAIL full_ready4: got %b want 0", mdu_ready); end
        tick();
        tests++; if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b1, 5'd10, 32'h10}) begin fails++; $display("FAIL full_m10: got %h want %h", {ctrl_writeEnable, ctrl_writeReg, data_writeReg}, {1'b1, 5'd10, 32'h10}); end
        tests++; if (mdu_ready !== 1'b1) begin fails++; $display("FAIL full_ready5: got %b want 1", mdu_ready); end
        tick();
        tests++; if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b1, 5'd11, 32'h11}) begin fails++; $display("FAIL full_m11: got %h want %h", {ctrl_writeEnable, ctrl_writeReg, data_writeReg}, {1'b1, 5'd11, 32'h11}); end
        mdu_valid = 0;
        tick();
        tests++; if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b1, 5'd12, 32'h12}) begin fails++; $display("FAIL full_m12: got %h want %h", {ctrl_writeEnable, ctrl_writeReg, data_writeReg}, {1'b1, 5'd12, 32'h12}); end
        tick();
        tests++; if (ctrl_writeEnable !== 1'b0) begin fails++; $display("FAIL full_idle: got %b want 0", ctrl_writeEnable); end
        tests++; if (pipe_hold !== 1'b0) begin fails++; $display("FAIL full_hold: got %b want 0", pipe_hold); end
    endtask

    task automatic test_starvation();
        idle();
        mdu_valid = 1; mdu_reg = 8; mdu_data = 32'h88; pipe_we = 1; pipe_reg = 1; pipe_data = 32'h100;
        tick();
        mdu_valid = 0;
        for (int i = 0; i < 4; i++) begin
            pipe_data = 32'h101 + i;
            tests++; if (pipe_hold !== 1'b0) begin fails++; $display("FAIL starve_nohold%0d: got %b want 0", i, pipe_hold); end
            tick();
            tests++; if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b1, 5'd1, 32'h101 + i}) begin fails++; $display("FAIL starve_pipe%0d: got %h want %h", i, {ctrl_writeEnable, ctrl_writeReg, data_writeReg}, {1'b1, 5'd1, 32'h101 + i}); end
        end
        tests++; if (pipe_hold !== 1'b1) begin fails++; $display("FAIL starve_hold: got %b want 1", pipe_hold); end
        pipe_we = 0;
        tick();
        tests++; if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b1, 5'd8, 32'h88}) begin fails++; $display("FAIL starve_head: got %h want %h", {ctrl_writeEnable, ctrl_writeReg, data_writeReg}, {1'b1, 5'd8, 32'h88}); end
        tests++; if (pipe_hold !== 1'b0) begin fails++; $display("FAIL starve_pulse: got %b want 0", pipe_hold); end
        tests++; if (err_sticky !== 1'b0) begin fails++; $display("FAIL starve_err: got %b want 0", err_sticky); end
    endtask

    task automatic test_hold_error();
        idle();
        mdu_valid = 1; mdu_reg = 8; mdu_data = 32'h77; pipe_we = 1; pipe_reg = 1; pipe_data = 32'h1;
        tick();
        mdu_valid = 0;
        repeat (4) tick();
        tests++; if (pipe_hold !== 1'b1) begin fails++; $display("FAIL herr_hold: got %b want 1", pipe_hold); end
        pipe_reg = 2; pipe_data = 32'h555;
        tick();
        tests++; if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b1, 5'd8, 32'h77}) begin fails++; $display("FAIL herr_head: got %h want %h", {ctrl_writeEnable, ctrl_writeReg, data_writeReg}, {1'b1, 5'd8, 32'h77}); end
        tests++; if (err_sticky !== 1'b1) begin fails++; $display("FAIL herr_set: got %b want 1", err_sticky); end
        pipe_we = 0;
        tick();
        tests++; if (err_sticky !== 1'b1) begin fails++; $display("FAIL herr_sticky: got %b want 1", err_sticky); end
    endtask

    task automatic test_mid_reset();
        idle();
        pipe_we = 1; pipe_reg = 4; pipe_data = 32'h44; mdu_valid = 1; mdu_reg = 21; mdu_data = 32'h21; issue_mdu = 1; issue_reg = 20;
        tick();
        tests++; if ({ctrl_writeEnable, ctrl_writeReg} !== {1'b1, 5'd4}) begin fails++; $display("FAIL mreset_inflight: got %h want %h", {ctrl_writeEnable, ctrl_writeReg}, {1'b1, 5'd4}); end
        idle();
        ctrl_reset = 1;
        tick();
        ctrl_reset = 0;
        tests++; if (ctrl_writeEnable !== 1'b0) begin fails++; $display("FAIL mreset_we: got %b want 0", ctrl_writeEnable); end
        tests++; if (err_sticky !== 1'b0) begin fails++; $display("FAIL mreset_err: got %b want 0", err_sticky); end
        tests++; if (mdu_ready !== 1'b1) begin fails++; $display("FAIL mreset_ready: got %b want 1", mdu_ready); end
        ctrl_readRegA = 20;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL mreset_pending: got %b want 0", stall); end
        tick();
        tests++; if (ctrl_writeEnable !== 1'b0) begin fails++; $display("FAIL mreset_fifo: got %b want 0", ctrl_writeEnable); end
    endtask

    task automatic test_scoreboard();
        logic exp_stall;
`ifdef REGFILE_BYPASS_EN
        exp_stall = 1'b0;
`else
        exp_stall = 1'b1;
`endif
        idle();
        issue_mdu = 1; issue_reg = 9;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL sb_issue: got %b want 0", stall); end
        tick();
        issue_mdu = 0; ctrl_readRegA = 9; mdu_valid = 1; mdu_reg = 9; mdu_data = 32'h99;
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL sb_rawA: got %b want 1", stall); end
        tick();
        mdu_valid = 0; ctrl_readRegA = 0; ctrl_readRegB = 9;
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL sb_rawB_pop: got %b want 1", stall); end
        tick();
        ctrl_readRegB = 0; ctrl_readRegA = 9;
        tests++; if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b1, 5'd9, 32'h99}) begin fails++; $display("FAIL sb_write: got %h want %h", {ctrl_writeEnable, ctrl_writeReg, data_writeReg}, {1'b1, 5'd9, 32'h99}); end
        tests++; if (stall !== exp_stall) begin fails++; $display("FAIL sb_clear_edge: got %b want %b", stall, exp_stall); end
`ifdef REGFILE_BYPASS_EN
        tests++; if ({bypass_hitA, bypass_hitB, bypass_data} !== {1'b1, 1'b0, 32'h99}) begin fails++; $display("FAIL sb_bypass: got %h want %h", {bypass_hitA, bypass_hitB, bypass_data}, {1'b1, 1'b0, 32'h99}); end
`endif
        tick();
        ctrl_readRegA = 0; dec_dst = 9;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL sb_cleared: got %b want 0", stall); end
        dec_dst = 0; issue_mdu = 1; issue_reg = 13;
        tick();
        mdu_valid = 1; mdu_reg = 13; mdu_data = 32'h13;
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL sb_issue_dup: got %b want 1", stall); end
        tick();
        idle();
        tick(); tick();
        ctrl_readRegA = 13;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL sb_r13_clear: got %b want 0", stall); end
    endtask

    task automatic test_reg0();
        idle();
        pipe_we = 1; pipe_reg = 0; pipe_data = 32'hBAD;
        tick();
        tests++; if (ctrl_writeEnable !== 1'b0) begin fails++; $display("FAIL r0_pipe: got %b want 0", ctrl_writeEnable); end
        pipe_we = 0; mdu_valid = 1; mdu_reg = 0; mdu_data = 32'hBAD; issue_mdu = 1; issue_reg = 0;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL r0_issue: got %b want 0", stall); end
        tick();
        mdu_valid = 0; issue_mdu = 0;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL r0_pending: got %b want 0", stall); end
        tick();
        tests++; if (ctrl_writeEnable !== 1'b0) begin fails++; $display("FAIL r0_mdu: got %b want 0", ctrl_writeEnable); end
        tests++; if (mdu_ready !== 1'b1) begin fails++; $display("FAIL r0_popped: got %b want 1", mdu_ready); end
        mdu_valid = 1; mdu_reg = 6; mdu_data = 32'h66;
        tick();
        mdu_valid = 0; pipe_we = 1; pipe_reg = 0;
        tick();
        tests++; if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b1, 5'd6, 32'h66}) begin fails++; $display("FAIL r0_yield: got %h want %h", {ctrl_writeEnable, ctrl_writeReg, data_writeReg}, {1'b1, 5'd6, 32'h66}); end
        pipe_we = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_pipe_write();
        test_contention();
        test_full_fifo();
        test_starvation();
        test_hold_error();
        test_mid_reset();
        test_scoreboard();
        test_reg0();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
